// File: rtl/fetch_queue.sv
// Instruction fetch stage: prefetches sequential instructions into an in-order
// queue in front of the decoder, holds after branch/jump-class instructions and
// flushes on redirect, discarding any response still in flight.
module fetch_queue #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INST_W   = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_en,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         req_valid,
  output logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_ready,
  input  logic                         resp_valid,
  input  logic [INST_W-1:0]            resp_inst,
  output logic                         dec_valid,
  output logic [ADDR_W-1:0]            dec_pc,
  output logic [INST_W-1:0]            dec_inst,
  input  logic                         dec_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitResp,
    StHoldBj,
    StDrain
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0]   occ_q, occ_d;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic accept, push, pop, flush, is_bj;

  // Handshake and queue event decode.
  assign accept = req_valid & req_ready;
  // A response coinciding with a redirect belongs to the old stream.
  assign push   = (state_q == StWaitResp) & resp_valid & ~redirect_en;
  assign pop    = dec_valid & dec_ready;
  assign flush  = redirect_en & (state_q != StIdle);
  assign is_bj  = resp_inst[6];

  // State, PC, pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  // Queue storage; contents need no reset since the head is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= pc_q;
      inst_mem_q[tail_q] <= resp_inst;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect_en) state_d = accept ? StDrain : StFetch;
        else if (accept) state_d = StWaitResp;
      end
      StWaitResp: begin
        // If the response lands with the redirect, nothing is left to drain.
        if (redirect_en)     state_d = resp_valid ? StFetch : StDrain;
        else if (resp_valid) state_d = is_bj ? StHoldBj : StFetch;
      end
      StHoldBj: begin
        if (redirect_en) state_d = StFetch;
      end
      StDrain: begin
        if (resp_valid) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      pc_d = redirect_pc;
    end else if (push && !is_bj) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // Queue pointer and occupancy update; a flush overrides push and pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (pop)  head_d = head_q + PtrW'(1);
      if (push) tail_d = tail_q + PtrW'(1);
      if (push && !pop)      occ_d = occ_q + OccW'(1);
      else if (pop && !push) occ_d = occ_q - OccW'(1);
    end
  end

  // Outputs decoded from the current state and queue contents.
  always_comb begin
    req_valid = (state_q == StFetch) && (occ_q < DepthOcc);
    req_addr  = pc_q;
    dec_valid = (occ_q != '0);
    dec_pc    = dec_valid ? pc_mem_q[head_q]   : '0;
    dec_inst  = dec_valid ? inst_mem_q[head_q] : '0;
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, redirect_en, req_ready, resp_valid, dec_ready;
  logic [31:0] redirect_pc, resp_inst;
  logic        req_valid, dec_valid;
  logic [31:0] req_addr, dec_pc, dec_inst;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  fetch_queue #(
    .ADDR_W  (32),
    .INST_W  (32),
    .DEPTH   (DEPTH),
    .PC_STEP (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .dec_valid  (dec_valid),
    .dec_pc     (dec_pc),
    .dec_inst   (dec_inst),
    .dec_ready  (dec_ready),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: an entry queue plus a few flags describing the fetch stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          m_init = 1'b0;
  bit          m_started, m_out, m_hold, m_drain, m_acc_last;
  logic [31:0] m_pc, m_acc_addr;
  logic [31:0] bj_addr;
  bit          resp_auto;

  function automatic bit m_req_valid();
    return m_started && !m_out && !m_hold && !m_drain && (mq.size() < DEPTH);
  endfunction

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == bj_addr) ? 32'h0000_0063 : {a[23:0], 8'h13};
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hdead_beef;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model update on each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit   acc, pop, still;
    ent_t e;
    acc        = m_req_valid() && req_ready;
    pop        = (mq.size() != 0) && dec_ready;
    m_acc_addr = m_pc;
    m_acc_last = !rst && acc;
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_started = 0; m_out = 0; m_hold = 0; m_drain = 0;
      m_init = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (redirect_en) begin
      still = ((m_out || m_drain) && !resp_valid) || acc;
      mq.delete();
      m_pc = redirect_pc; m_hold = 0; m_out = 0; m_drain = still;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_drain && resp_valid) begin
        m_drain = 1'b0;
      end else if (m_out && resp_valid) begin
        e.pc = m_pc; e.inst = resp_inst;
        mq.push_back(e);
        m_out = 1'b0;
        if (resp_inst[6]) m_hold = 1'b1;
        else              m_pc   = m_pc + 32'd4;
      end
      if (acc) m_out = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("req_valid", 32'(req_valid), 32'(m_req_valid()));
      chk("req_addr",  req_addr, m_pc);
      chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
      chk("dec_pc",    dec_pc,   (mq.size() != 0) ? mq[0].pc   : 32'h0);
      chk("dec_inst",  dec_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
    end
  end

  // One clock; the memory responder answers an accepted request the next cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (resp_auto) begin
      resp_valid = m_acc_last;
      resp_inst  = m_acc_last ? imem(m_acc_addr) : 32'h0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    chk({tag, "_req_addr"},  req_addr, 32'h0);
    chk({tag, "_dec_valid"}, 32'(dec_valid), 32'h0);
    chk({tag, "_dec_pc"},    dec_pc, 32'h0);
    chk({tag, "_dec_inst"},  dec_inst, 32'h0);
    chk({tag, "_occ"},       32'(occupancy), 32'h0);
  endtask

  logic [31:0] seen[$];
  logic [31:0] addrs[$];
  int first_dv, max_occ;

  initial begin
    rst = 1; redirect_en = 0; redirect_pc = 0; req_ready = 0; resp_valid = 0;
    resp_inst = 0; dec_ready = 0; resp_auto = 1; bj_addr = 32'hffff_fff0;
    cyc(); cyc();
    chk_reset_outputs("reset");

    // Zero-wait memory, decoder always ready.
    rst = 0; req_ready = 1; dec_ready = 1; first_dv = -1; max_occ = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (dec_valid) begin
        if (first_dv < 0) first_dv = c;
        seen.push_back(dec_pc);
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    chk("t1_first_dec_valid", 32'(first_dv), 32'd3);
    chk("t1_max_occ", 32'(max_occ), 32'd1);
    chk("t1_pc0", qget(seen, 0), 32'h0);
    chk("t1_pc1", qget(seen, 1), 32'h4);
    chk("t1_pc2", qget(seen, 2), 32'h8);

    // Decoder stalled: queue fills, then one pop reopens fetch.
    rst = 1; dec_ready = 0; cyc(); rst = 0;
    addrs.delete();
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (req_valid && req_ready) addrs.push_back(req_addr);
    end
    chk("t2_nreq", 32'(addrs.size()), 32'd4);
    chk("t2_addr0", qget(addrs, 0), 32'h0);
    chk("t2_addr3", qget(addrs, 3), 32'hc);
    chk("t2_occ_full", 32'(occupancy), 32'd4);
    chk("t2_req_off", 32'(req_valid), 32'h0);
    dec_ready = 1; cyc(); dec_ready = 0;
    chk("t2_occ_after_pop", 32'(occupancy), 32'd3);
    chk("t2_req_on", 32'(req_valid), 32'h1);
    chk("t2_req_addr", req_addr, 32'h10);

    // Push and pop together at DEPTH-1, then order across the pointer wrap.
    cyc();
    chk("t5_wait_occ", 32'(occupancy), 32'd3);
    dec_ready = 1; cyc();
    chk("t5_occ_same", 32'(occupancy), 32'd3);
    chk("t5_head", dec_pc, 32'h8);
    seen.delete();
    for (int c = 0; c < 6; c++) begin
      if (dec_valid) seen.push_back(dec_pc);
      cyc();
    end
    chk("t5_ord0", qget(seen, 0), 32'h8);
    chk("t5_ord1", qget(seen, 1), 32'hc);
    chk("t5_ord2", qget(seen, 2), 32'h10);
    chk("t5_ord3", qget(seen, 3), 32'h14);

    // Branch-class instruction at 0x8 holds fetch until redirected.
    rst = 1; dec_ready = 0; bj_addr = 32'h8; cyc(); rst = 0;
    addrs.delete();
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (req_valid && req_ready) addrs.push_back(req_addr);
    end
    chk("t3_nreq", 32'(addrs.size()), 32'd3);
    chk("t3_occ", 32'(occupancy), 32'd3);
    chk("t3_req_off", 32'(req_valid), 32'h0);
    chk("t3_head_inst", dec_inst, 32'h0000_0013);
    redirect_en = 1; redirect_pc = 32'h100; dec_ready = 1; cyc();
    redirect_en = 0; dec_ready = 0;
    chk("t3_occ_flushed", 32'(occupancy), 32'd0);
    chk("t3_req_on", 32'(req_valid), 32'h1);
    chk("t3_req_addr", req_addr, 32'h100);
    for (int c = 0; c < 4; c++) cyc();

    // Redirect while a response is outstanding with two entries queued.
    rst = 1; bj_addr = 32'hffff_fff0; dec_ready = 0; cyc(); rst = 0;
    for (int c = 1; c <= 5; c++) cyc();
    resp_auto = 0; cyc();
    chk("t4_occ2", 32'(occupancy), 32'd2);
    chk("t4_waiting", 32'(req_valid), 32'h0);
    redirect_en = 1; redirect_pc = 32'h40; cyc();
    redirect_en = 0; resp_valid = 1; resp_inst = 32'h0bad_0013;
    chk("t4_occ0", 32'(occupancy), 32'd0);
    chk("t4_drain_req", 32'(req_valid), 32'h0);
    cyc(); resp_valid = 0;
    chk("t4_dropped", 32'(dec_valid), 32'h0);
    chk("t4_req_on", 32'(req_valid), 32'h1);
    chk("t4_req_addr", req_addr, 32'h40);
    resp_auto = 1;
    for (int c = 0; c < 4; c++) cyc();

    // Reset mid-operation with a request outstanding; stale response ignored.
    rst = 1; cyc(); rst = 0; dec_ready = 0;
    for (int c = 1; c <= 7; c++) cyc();
    resp_auto = 0; cyc();
    chk("t6_occ3", 32'(occupancy), 32'd3);
    chk("t6_waiting", 32'(req_valid), 32'h0);
    rst = 1; cyc(); rst = 0; resp_valid = 1; resp_inst = 32'h1234_0013;
    chk_reset_outputs("t6_reset");
    cyc(); resp_valid = 0;
    chk("t6_stale_dec_valid", 32'(dec_valid), 32'h0);
    chk("t6_stale_occ", 32'(occupancy), 32'd0);
    chk("t6_req_on", 32'(req_valid), 32'h1);
    chk("t6_req_addr", req_addr, 32'h0);
    resp_auto = 1; dec_ready = 1;
    for (int c = 0; c < 6; c++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage sitting between the instruction memory/icache port and the decoder.
- Prefetches sequential instructions into a DEPTH-entry in-order queue, so decoder stalls no longer block memory traffic.
- Stops prefetching after a branch/jump-class instruction until redirected.
- A redirect flushes the queue and discards any in-flight response.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width; bit 6 is the branch/jump class flag.
- DEPTH, 4, queue entries; power of two, at least 2.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_en  in  1  jump/branch target valid this cycle.
- redirect_pc  in  ADDR_W  new fetch address.
- req_valid  out  1  fetch request to memory/icache.
- req_addr  out  ADDR_W  fetch address.
- req_ready  in  1  memory accepts the request this cycle.
- resp_valid  in  1  instruction returned, one per accepted request, in order.
- resp_inst  in  INST_W  returned instruction.
- dec_valid  out  1  queue head valid toward decoder.
- dec_pc  out  ADDR_W  PC of head entry.
- dec_inst  out  INST_W  instruction of head entry.
- dec_ready  in  1  decoder not stalled; pops head when dec_valid is high.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset: state IDLE, pc=RESET_PC, queue empty.
  - Outputs: req_valid=0, req_addr=RESET_PC, dec_valid=0, dec_pc=0, dec_inst=0, occupancy=0.
  - Reset mid-operation drops all entries and any outstanding request; a later resp_valid is ignored until a new request is accepted.
- States: IDLE, FETCH, WAIT_RESP, HOLD_BJ, DRAIN.
  - IDLE goes to FETCH unconditionally, so the first req_valid appears one cycle after rst drops.
- FETCH:
  - req_valid = (occupancy < DEPTH); req_addr = pc.
  - req_valid and req_addr stay stable until req_ready. Withdrawal is allowed only on redirect or rst.
  - Acceptance (req_valid & req_ready) goes to WAIT_RESP. At most one request is outstanding.
- WAIT_RESP:
  - req_valid=0. resp_valid arrives no earlier than the cycle after acceptance.
  - On resp_valid, push {pc, resp_inst}. Space is guaranteed because occupancy<DEPTH was checked at issue.
  - If resp_inst[6]=1, go to HOLD_BJ with pc unchanged.
  - Otherwise pc <= pc + PC_STEP (mod 2^ADDR_W) and go to FETCH.
- HOLD_BJ: req_valid=0; wait for redirect_en.
- Redirect (redirect_en=1), highest priority after rst, in any non-IDLE state:
  - Queue flushed, pc <= redirect_pc.
  - Goes to DRAIN if a request is outstanding (WAIT_RESP, or FETCH with acceptance in the same cycle); otherwise to FETCH.
  - A pop in the same cycle still counts as delivered; the flush clears whatever remains.
  - A push in the same cycle is discarded.
- DRAIN:
  - req_valid=0. The next resp_valid is discarded (not pushed), then go to FETCH.
  - A redirect in DRAIN updates pc and stays in DRAIN.
- Queue behaviour:
  - Circular buffer with ADDR-independent pointers wrapping at DEPTH.
  - dec_valid = occupancy != 0; dec_pc and dec_inst show the head entry, registered storage read combinationally.
  - Pop on dec_valid & dec_ready. Simultaneous push and pop keeps occupancy unchanged.
  - Pop on empty has no effect.
  - Full queue: req_valid=0 in FETCH until a pop frees a slot. req_valid rises the cycle after the pop.
- Latency: with zero-wait memory (req_ready=1, response 1 cycle later), sequential throughput is one instruction per 2 cycles. An accepted instruction is visible on dec_* the cycle after its resp_valid.

Test Plan:
- Reset, then req_ready=1 and resp 1 cycle later with non-BJ insts, dec_ready=1:
  - dec_pc sequence 0x0, 0x4, 0x8.
  - First dec_valid 3 cycles after rst drops; occupancy never exceeds 1.
- dec_ready=0 with DEPTH=4:
  - Exactly 4 requests (0x0 to 0xC) issued, occupancy=4, req_valid stays 0.
  - Raise dec_ready for one cycle: occupancy 3, req_addr=0x10 next cycle.
- Response inst 0x00000063 (bit6=1) at pc 0x8:
  - HOLD_BJ, no further req_valid.
  - redirect_en with redirect_pc=0x100: next req_addr=0x100.
  - The 0x8 entry is still delivered before the flush only if popped that cycle.
- redirect_en=1 with pc 0x40 while in WAIT_RESP and occupancy=2:
  - occupancy becomes 0, resp next cycle is dropped (dec_valid stays 0).
  - The following request goes to 0x40.
- Push and pop in the same cycle at occupancy=DEPTH-1: occupancy unchanged, FIFO order preserved across pointer wrap.
- Assert rst while occupancy=3 and a request is outstanding: all outputs return to reset values; the stale resp_valid after reset is ignored.
